dm: RTL and testbench

Data memory for the five-stage MIPS pipeline, located in the MEM stage directly downstream of the EX/MEM register. It consumes that register's memory-operation code, address (ALU output), store data and PC. It performs byte, halfword or word stores on the clock edge and returns sign- or zero-extended load data combinationally to the MEM/WB register. Every committed store is also published on a registered write-trace port, which the bench uses to check the store stream.

---
 rtl/dm_pkg.sv | 17 +
 rtl/dm_lane.sv | 51 +++++
 rtl/dm.sv | 103 ++++++++++
 tb/tb_dm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared memory-operation encoding for the MEM stage and the EX/MEM control decode.
package dm_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'd0;
    localparam logic [2:0] MEMOP_LBU = 3'd1;
    localparam logic [2:0] MEMOP_LH  = 3'd2;
    localparam logic [2:0] MEMOP_LHU = 3'd3;
    localparam logic [2:0] MEMOP_LW  = 3'd4;
    localparam logic [2:0] MEMOP_SB  = 3'd5;
    localparam logic [2:0] MEMOP_SH  = 3'd6;
    localparam logic [2:0] MEMOP_SW  = 3'd7;

    function automatic logic is_store(input logic [2:0] mem_op);
        return mem_op[2] & (|mem_op[1:0]);
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for the data memory: store byte enables and aligned data,
// and sign/zero extension of the selected load lane.
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wd,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wd_aligned,
    output logic [31:0] rd_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Replicating the low byte/half across the word puts it in every lane,
    // so the byte enables alone decide where it lands.
    always_comb begin
        byte_en    = 4'b0000;
        wd_aligned = wd;
        case (mem_op)
            MEMOP_SB: begin
                byte_en    = 4'b0001 << byte_off;
                wd_aligned = {4{wd[7:0]}};
            end
            MEMOP_SH: begin
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                wd_aligned = {2{wd[15:0]}};
            end
            MEMOP_SW: byte_en = 4'b1111;
            default:  byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        byte_sel = raw_word[8*byte_off +: 8];
        half_sel = byte_off[1] ? raw_word[31:16] : raw_word[15:0];
        rd_ext   = '0;
        case (mem_op)
            MEMOP_LB:  rd_ext = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_LBU: rd_ext = {24'h0, byte_sel};
            MEMOP_LH:  rd_ext = {{16{half_sel[15]}}, half_sel};
            MEMOP_LHU: rd_ext = {16'h0, half_sel};
            MEMOP_LW:  rd_ext = raw_word;
            default:   rd_ext = '0;
        endcase
    end

endmodule

// File: rtl/dm.sv
// MEM-stage data memory: combinational extended loads, byte/half/word stores on
// the rising edge, and a registered trace of every committed store.
module dm
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          we;
    logic [31:0]   raw_word;
    logic [3:0]    byte_en;
    logic [31:0]   wd_aligned;
    logic [31:0]   bit_mask;
    logic [31:0]   merged_word;

    logic          trace_valid_d, trace_valid_q;
    logic [31:0]   trace_pc_d, trace_pc_q;
    logic [31:0]   trace_addr_d, trace_addr_q;
    logic [31:0]   trace_data_d, trace_data_q;

    assign word_idx = Addr[AW+1:2];
    assign in_range = (Addr[31:AW+2] == '0);
    assign we       = is_store(MemOp) & in_range;
    assign raw_word = in_range ? mem_q[word_idx] : 32'h0;

    dm_lane u_lane (
        .mem_op     (MemOp),
        .byte_off   (Addr[1:0]),
        .wd         (WD),
        .raw_word   (raw_word),
        .byte_en    (byte_en),
        .wd_aligned (wd_aligned),
        .rd_ext     (RD)
    );

    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < 4; k++) begin
            bit_mask[8*k +: 8] = {8{byte_en[k]}};
        end
        merged_word = (raw_word & ~bit_mask) | (wd_aligned & bit_mask);
    end

    // NOTE: the array is cleared by the asynchronous reset, so it is built from
    // flops (one clear-and-load register per word) rather than a RAM macro.
    for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q[w] <= '0;
            end else if (we && (word_idx == AW'(w))) begin
                mem_q[w] <= merged_word;
            end
        end
    end

    always_comb begin
        trace_valid_d = we;
        trace_pc_d    = trace_pc_q;
        trace_addr_d  = trace_addr_q;
        trace_data_d  = trace_data_q;
        if (we) begin
            trace_pc_d   = PC;
            trace_addr_d = {Addr[31:2], 2'b00};
            trace_data_d = merged_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_dm.sv
// Self-checking bench for dm: byte-addressed reference model checked every cycle,
// plus directed literal expectations.
module tb_dm;
    import dm_pkg::*;

    localparam int DEPTH = 4096;
    localparam int BYTES = DEPTH * 4;

    logic        clk;
    logic        reset;
    logic [2:0]  MemOp;
    logic [31:0] Addr, WD, PC;
    logic [31:0] RD;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_addr, trace_data;

    int total = 0;
    int bad   = 0;
    bit run   = 0;

    logic [7:0]  mem_b [BYTES];
    logic        exp_tv;
    logic [31:0] exp_pc, exp_addr, exp_data;

    dm #(.DEPTH_WORDS(DEPTH), .AW(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemOp       (MemOp),
        .Addr        (Addr),
        .WD          (WD),
        .PC          (PC),
        .RD          (RD),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input int base);
        return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
    endfunction

    // Reference load: byte-addressed view, extension done arithmetically.
    function automatic logic [31:0] model_rd(input logic [2:0] m, input logic [31:0] a);
        logic [31:0] v;
        int          ai;
        if (a >= 32'(BYTES)) return 32'h0;
        ai = int'(a);
        case (m)
            MEMOP_LB, MEMOP_LBU: begin
                v = {24'h0, mem_b[ai]};
                if (m == MEMOP_LB && v >= 32'd128) v = v - 32'd256;
            end
            MEMOP_LH, MEMOP_LHU: begin
                ai = ai - (ai % 2);
                v = {16'h0, mem_b[ai+1], mem_b[ai]};
                if (m == MEMOP_LH && v >= 32'd32768) v = v - 32'd65536;
            end
            MEMOP_LW: v = word_at(ai - (ai % 4));
            default:  v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BYTES; i++) mem_b[i] = 8'h0;
            exp_tv = 0; exp_pc = 0; exp_addr = 0; exp_data = 0;
        end else begin
            exp_tv = 0;
            if (MemOp >= 3'd5 && Addr < 32'(BYTES)) begin
                int ai;
                ai = int'(Addr);
                case (MemOp)
                    MEMOP_SB: mem_b[ai] = WD[7:0];
                    MEMOP_SH: begin
                        ai = ai - (ai % 2);
                        mem_b[ai]   = WD[7:0];
                        mem_b[ai+1] = WD[15:8];
                    end
                    default: begin
                        ai = ai - (ai % 4);
                        for (int k = 0; k < 4; k++) mem_b[ai+k] = WD[8*k +: 8];
                    end
                endcase
                ai       = int'(Addr) - (int'(Addr) % 4);
                exp_tv   = 1;
                exp_pc   = PC;
                exp_addr = 32'(ai);
                exp_data = word_at(ai);
            end
        end
    end

    always @(negedge clk) begin
        if (run && reset) begin
            if (MemOp <= MEMOP_LW) check("model_rd", RD, model_rd(MemOp, Addr));
            check("model_trace_valid", {31'h0, trace_valid}, {31'h0, exp_tv});
            check("model_trace_pc", trace_pc, exp_pc);
            check("model_trace_addr", trace_addr, exp_addr);
            check("model_trace_data", trace_data, exp_data);
        end
    end

    task automatic op(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] pc);
        @(posedge clk);
        #1;
        MemOp = m; Addr = a; WD = wd; PC = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; MemOp = MEMOP_LW; Addr = 0; WD = 0; PC = 0;
        #3 reset = 1'b0;
        #10 reset = 1'b1;
        run = 1;

        op(MEMOP_LW, 32'h0, 32'h0, 32'h0040_0000);
        #1 check("reset_rd", RD, 32'h0);
        check("reset_tv", {31'h0, trace_valid}, 32'h0);

        op(MEMOP_SW, 32'h10, 32'h80FF_7F01, 32'h0040_0004);
        op(MEMOP_LB, 32'h10, 32'h0, 32'h0040_0008);
        #1 check("lb_10", RD, 32'h0000_0001);
        op(MEMOP_LB, 32'h11, 32'h0, 32'h0040_000C);
        #1 check("lb_11", RD, 32'h0000_007F);
        op(MEMOP_LB, 32'h12, 32'h0, 32'h0040_0010);
        #1 check("lb_12", RD, 32'hFFFF_FFFF);
        op(MEMOP_LB, 32'h13, 32'h0, 32'h0040_0014);
        #1 check("lb_13", RD, 32'hFFFF_FF80);
        op(MEMOP_LBU, 32'h13, 32'h0, 32'h0040_0018);
        #1 check("lbu_13", RD, 32'h0000_0080);

        op(MEMOP_SW, 32'h20, 32'h1122_3344, 32'h0040_001C);
        op(MEMOP_SH, 32'h22, 32'hAAAA_BEEF, 32'h0040_0020);
        op(MEMOP_LW, 32'h20, 32'h0, 32'h0040_0024);
        #1 check("lw_20_after_sh", RD, 32'hBEEF_3344);
        check("sh_trace_valid", {31'h0, trace_valid}, 32'h1);
        check("sh_trace_pc", trace_pc, 32'h0040_0020);
        check("sh_trace_addr", trace_addr, 32'h0000_0020);
        check("sh_trace_data", trace_data, 32'hBEEF_3344);
        op(MEMOP_LH, 32'h22, 32'h0, 32'h0040_0028);
        #1 check("lh_22", RD, 32'hFFFF_BEEF);
        op(MEMOP_LHU, 32'h23, 32'h0, 32'h0040_002C);
        #1 check("lhu_23", RD, 32'h0000_BEEF);

        op(MEMOP_SB, 32'h7, 32'h0000_005A, 32'h0040_0030);
        op(MEMOP_LW, 32'h4, 32'h0, 32'h0040_0034);
        #1 check("lw_4_after_sb", RD, 32'h5A00_0000);
        op(MEMOP_LB, 32'h4, 32'hFFFF_FFFF, 32'h0040_0038);
        op(MEMOP_LW, 32'h6, 32'h0, 32'h0040_003C);
        #1 check("lw_4_after_lb", RD, 32'h5A00_0000);
        check("load_no_trace", {31'h0, trace_valid}, 32'h0);

        op(MEMOP_SW, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0040_0040);
        op(MEMOP_LW, 32'h0000_4000, 32'h0, 32'h0040_0044);
        #1 check("oor_no_trace", {31'h0, trace_valid}, 32'h0);
        check("oor_load", RD, 32'h0);
        op(MEMOP_LW, 32'h0, 32'h0, 32'h0040_0048);
        #1 check("word0_untouched", RD, 32'h0);

        op(MEMOP_SW, 32'h30, 32'hCAFE_0001, 32'h0040_0050);
        op(MEMOP_SW, 32'h34, 32'hCAFE_0002, 32'h0040_0054);
        #1 check("b2b_tv1", {31'h0, trace_valid}, 32'h1);
        op(MEMOP_SW, 32'h38, 32'hCAFE_0003, 32'h0040_0058);
        #1 check("b2b_tv2", {31'h0, trace_valid}, 32'h1);
        op(MEMOP_LW, 32'h30, 32'h0, 32'h0040_005C);
        #1 check("b2b_tv3", {31'h0, trace_valid}, 32'h1);
        check("b2b_data3", trace_data, 32'hCAFE_0003);
        check("pre_reset_lw30", RD, 32'hCAFE_0001);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check("rst_tv", {31'h0, trace_valid}, 32'h0);
        check("rst_trace_data", trace_data, 32'h0);
        check("rst_trace_pc", trace_pc, 32'h0);
        check("rst_rd_30", RD, 32'h0);
        #1 reset = 1'b1;
        op(MEMOP_LW, 32'h30, 32'h0, 32'h0040_0060);
        #1 check("post_rst_30", RD, 32'h0);
        op(MEMOP_LW, 32'h34, 32'h0, 32'h0040_0064);
        #1 check("post_rst_34", RD, 32'h0);
        op(MEMOP_LW, 32'h38, 32'h0, 32'h0040_0068);
        #1 check("post_rst_38", RD, 32'h0);

        op(MEMOP_LW, 32'h10, 32'h0, 32'h0040_006C);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
